// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed seven-segment driver for DIGITS hex digits.
// Scans one digit per REFRESH_TICKS-cycle slot and blanks every digit for the
// first GUARD_TICKS cycles of a slot so that no digit shows the previous
// digit's segments. A new value is staged in a pending register and copied
// into the display register only at the frame wrap, so a frame never mixes
// old and new digits.
// Optional: define SEG7_DIMMING_EN to add a 4-bit PWM brightness input.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   value_in     4*DIGITS hex value, nibble i -> digit i (digit 0 rightmost)
//   dp_in        per-digit decimal point, active high
//   load         level-sampled capture of value_in/dp_in into pending
//   blank_lz     live enable for leading-zero blanking
//   brightness   (SEG7_DIMMING_EN only) on-duty in sixteenths
//   load_ack     one-cycle pulse when pending moves to the display
//   frame_start  one-cycle pulse when the scan wraps to digit 0
//   anode        digit enables, active low
//   segments     {A,B,C,D,E,F,G}, active high
//   dp           decimal point of the lit digit, active high
module seg7_scan_driver #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned REFRESH_TICKS = 120000,
  parameter int unsigned GUARD_TICKS   = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4*DIGITS-1:0] value_in,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                load,
  input  logic                blank_lz,
`ifdef SEG7_DIMMING_EN
  input  logic [3:0]          brightness,
`endif
  output logic                load_ack,
  output logic                frame_start,
  output logic [DIGITS-1:0]   anode,
  output logic [6:0]          segments,
  output logic                dp
);

  localparam int unsigned TICK_W = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
  localparam int unsigned SLOT_W = $clog2(DIGITS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_TICKS - 1);
  localparam logic [TICK_W-1:0] GUARD_END = TICK_W'(GUARD_TICKS);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIGITS - 1);

  logic [TICK_W-1:0]      tick_q;
  logic [SLOT_W-1:0]      slot_q;
  logic [DIGITS-1:0][3:0] pend_q;
  logic [DIGITS-1:0]      pend_dp_q;
  logic                   pend_flag_q;
  logic [DIGITS-1:0][3:0] disp_q;
  logic [DIGITS-1:0]      disp_dp_q;

  logic                   slot_wrap_c;
  logic                   frame_wrap_c;
  logic [DIGITS-1:0]      lz_mask_c;
  logic                   pwm_on_c;
  logic                   lit_c;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    s = 7'h00;
    case (h)
      4'h0: s = 7'h7E;  4'h1: s = 7'h30;  4'h2: s = 7'h6D;  4'h3: s = 7'h79;
      4'h4: s = 7'h33;  4'h5: s = 7'h5B;  4'h6: s = 7'h5F;  4'h7: s = 7'h70;
      4'h8: s = 7'h7F;  4'h9: s = 7'h7B;  4'hA: s = 7'h77;  4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;  4'hD: s = 7'h3D;  4'hE: s = 7'h4F;  4'hF: s = 7'h47;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign slot_wrap_c  = (tick_q == TICK_LAST);
  assign frame_wrap_c = slot_wrap_c && (slot_q == SLOT_LAST);

  // Digit i (i>0) is a leading zero when it and every digit above it are zero.
  always_comb begin
    logic zero_above;
    lz_mask_c  = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above   = zero_above & (disp_q[i] == 4'h0);
      lz_mask_c[i] = zero_above;
    end
  end

`ifdef SEG7_DIMMING_EN
  logic [3:0] pwm_q;

  // Free-running PWM phase for brightness control.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pwm_q <= 4'd0;
    else        pwm_q <= pwm_q + 4'd1;
  end

  assign pwm_on_c = (pwm_q < brightness);
`else
  assign pwm_on_c = 1'b1;
`endif

  assign lit_c = (tick_q >= GUARD_END) && !(blank_lz && lz_mask_c[slot_q]) && pwm_on_c;

  // Tick and slot scan counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q <= '0;
      slot_q <= '0;
    end else if (slot_wrap_c) begin
      tick_q <= '0;
      slot_q <= (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
    end else begin
      tick_q <= tick_q + TICK_W'(1);
    end
  end

  // Pending/display registers; a load in the wrap cycle lands in pending for the next frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q      <= '0;
      pend_dp_q   <= '0;
      pend_flag_q <= 1'b0;
      disp_q      <= '0;
      disp_dp_q   <= '0;
    end else begin
      if (frame_wrap_c && pend_flag_q) begin
        disp_q    <= pend_q;
        disp_dp_q <= pend_dp_q;
      end
      if (load) begin
        pend_q      <= value_in;
        pend_dp_q   <= dp_in;
        pend_flag_q <= 1'b1;
      end else if (frame_wrap_c) begin
        pend_flag_q <= 1'b0;
      end
    end
  end

  // Registered pin stage: anode and segments switch on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
      anode       <= '1;
      segments    <= 7'h00;
      dp          <= 1'b0;
    end else begin
      load_ack    <= frame_wrap_c && pend_flag_q;
      frame_start <= frame_wrap_c;
      if (lit_c) begin
        anode    <= ~(DIGITS'(1) << slot_q);
        segments <= hex_to_seg(disp_q[slot_q]);
        dp       <= disp_dp_q[slot_q];
      end else begin
        anode    <= '1;
        segments <= 7'h00;
        dp       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (DIGITS=4, REFRESH_TICKS=8, GUARD_TICKS=1).
// The reference derives the scan position from the number of clock edges
// since reset and looks segment patterns up in a table.
module tb_seg7_scan_driver;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned RT     = 8;
  localparam int unsigned GT     = 1;
  localparam int unsigned F      = DIGITS * RT;
  localparam logic [13:0] RESET_OBS = {1'b0, 1'b0, 4'hF, 7'h00, 1'b0};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
`ifdef SEG7_DIMMING_EN
  logic [3:0]  brightness = 4'd15;
`endif
  logic        load_ack, frame_start, dp;
  logic [3:0]  anode;
  logic [6:0]  segments;
  logic [13:0] obs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(DIGITS), .REFRESH_TICKS(RT), .GUARD_TICKS(GT)) dut (
    .clk(clk), .reset(reset), .value_in(value_in), .dp_in(dp_in),
    .load(load), .blank_lz(blank_lz),
`ifdef SEG7_DIMMING_EN
    .brightness(brightness),
`endif
    .load_ack(load_ack), .frame_start(frame_start),
    .anode(anode), .segments(segments), .dp(dp)
  );

  assign obs = {load_ack, frame_start, anode, segments, dp};

  // Reference model state.
  logic [6:0]  seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  int          m_k;
  logic [15:0] m_pend, m_disp;
  logic [3:0]  m_pdp, m_ddp;
  logic        m_flag;
  logic [13:0] exp_vec = RESET_OBS;

  always @(posedge clk or negedge reset) begin
    int p, tk, sl;
    logic on, fs, ack;
    logic [3:0] nib;
    if (!reset) begin
      m_k = 0; m_pend = '0; m_disp = '0; m_pdp = '0; m_ddp = '0; m_flag = 1'b0;
      exp_vec = RESET_OBS;
    end else begin
      p  = m_k % F;
      tk = p % RT;
      sl = p / RT;
      nib = 4'((m_disp >> (4 * sl)) & 16'h000F);
      on = (tk >= GT) && !(blank_lz && sl > 0 && (m_disp >> (4 * sl)) == 16'h0);
`ifdef SEG7_DIMMING_EN
      on = on && ((m_k % 16) < int'(brightness));
`endif
      fs  = (p == F - 1);
      ack = fs && m_flag;
      exp_vec = {ack, fs, on ? ~(4'b0001 << sl) : 4'hF,
                 on ? seg_tab[nib] : 7'h00, on ? m_ddp[sl] : 1'b0};
      if (ack) begin
        m_disp = m_pend; m_ddp = m_pdp; m_flag = 1'b0;
      end
      if (load) begin
        m_pend = value_in; m_pdp = dp_in; m_flag = 1'b1;
      end
      m_k++;
    end
  end

  task automatic test_reset();
    int fs_count = 0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== RESET_OBS) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", obs, RESET_OBS);
    end
    #2 reset = 1'b1;
    for (int n = 0; n < 2 * F; n++) begin
      @(posedge clk); #1;
      if (frame_start === 1'b1) fs_count++;
      checks++;
      if (obs !== exp_vec) begin
        failures++; $display("FAIL idle_scan k=%0d got=%h exp=%h", m_k, obs, exp_vec);
      end
    end
    checks++;
    if (fs_count != 2) begin
      failures++; $display("FAIL frame_start_rate got=%0d exp=2", fs_count);
    end
  endtask

  task automatic test_load_midslot();
    for (int n = 0; n < F && (m_k % F) != 2 * RT + 3; n++) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== exp_vec) begin
        failures++; $display("FAIL load_wait k=%0d got=%h exp=%h", m_k, obs, exp_vec);
      end
    end
    value_in = 16'h1A2F; dp_in = 4'b0010; load = 1'b1;
    for (int n = 0; n < 2 * F; n++) begin
      @(posedge clk); #1;
      load = 1'b0;
      checks++;
      if (obs !== exp_vec) begin
        failures++; $display("FAIL load_midslot k=%0d got=%h exp=%h", m_k, obs, exp_vec);
      end
      if (anode == 4'b1101 && n > F) begin
        checks++;
        if ({segments, dp} !== {7'h6D, 1'b1}) begin
          failures++; $display("FAIL digit1_1A2F got=%h exp=%h", {segments, dp}, {7'h6D, 1'b1});
        end
      end
    end
  endtask

  task automatic test_blank_lz();
    logic [15:0] vals [2] = '{16'h0005, 16'h0105};
    blank_lz = 1'b1;
    for (int v = 0; v < 2; v++) begin
      value_in = vals[v]; dp_in = 4'b1111; load = 1'b1;
      for (int n = 0; n < 2 * F; n++) begin
        @(posedge clk); #1;
        load = 1'b0;
        checks++;
        if (obs !== exp_vec) begin
          failures++; $display("FAIL blank_lz v=%h k=%0d got=%h exp=%h", vals[v], m_k, obs, exp_vec);
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    for (int n = 0; n < F && (m_k % F) != 2; n++) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== exp_vec) begin
        failures++; $display("FAIL b2b_wait k=%0d got=%h exp=%h", m_k, obs, exp_vec);
      end
    end
    dp_in = 4'b0000;
    for (int n = 0; n < 2 * F; n++) begin
      load = (n == 0) || (n == 9);
      value_in = (n < 9) ? 16'h1111 : 16'h2222;
      @(posedge clk); #1;
      if (load_ack === 1'b1) acks++;
      checks++;
      if (obs !== exp_vec) begin
        failures++; $display("FAIL back_to_back k=%0d got=%h exp=%h", m_k, obs, exp_vec);
      end
    end
    load = 1'b0;
    checks++;
    if (acks != 1) begin
      failures++; $display("FAIL single_ack got=%0d exp=1", acks);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== exp_vec) begin
        failures++; $display("FAIL random k=%0d got=%h exp=%h", m_k, obs, exp_vec);
      end
      load     = ($urandom_range(5) == 0);
      value_in = 16'($urandom) >> (4 * $urandom_range(3));
      dp_in    = 4'($urandom);
      if ($urandom_range(29) == 0) blank_lz = ~blank_lz;
`ifdef SEG7_DIMMING_EN
      if ($urandom_range(49) == 0) brightness = 4'($urandom);
`endif
    end
    load = 1'b0; blank_lz = 1'b0;
  endtask

  task automatic test_reset_midslot();
    value_in = 16'h1234; dp_in = 4'b0000; load = 1'b1;
    for (int n = 0; n < 3 * F && !(n > F && (m_k % F) == 2 * RT + 4); n++) begin
      @(posedge clk); #1;
      load = 1'b0;
      checks++;
      if (obs !== exp_vec) begin
        failures++; $display("FAIL pre_reset k=%0d got=%h exp=%h", m_k, obs, exp_vec);
      end
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs !== RESET_OBS) begin
      failures++; $display("FAIL async_reset got=%h exp=%h", obs, RESET_OBS);
    end
    @(posedge clk); #3 reset = 1'b1;
    for (int n = 0; n < F + RT; n++) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== exp_vec) begin
        failures++; $display("FAIL post_reset k=%0d got=%h exp=%h", m_k, obs, exp_vec);
      end
      if (anode != 4'hF) begin
        checks++;
        if (segments !== 7'h7E) begin
          failures++; $display("FAIL post_reset_zero got=%h exp=7e", segments);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_midslot();
    test_blank_lz();
    test_back_to_back();
    test_random();
    test_reset_midslot();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised multiplexed seven-segment display driver for DIGITS hex digits. Successor to the fixed 4-digit scan logic in the top-level app.
- Adds a tear-free shadowed value load with acknowledge, anti-ghosting guard blanking, leading-zero blanking, per-digit decimal points and a frame-start strobe.
- Sits between processor/counter outputs and the board anode/segment pins.

Parameters:
- DIGITS, 4, number of digits; 2..8.
- REFRESH_TICKS, 120000, clk cycles per digit slot (5 ms at 24 MHz); must be >= GUARD_TICKS+2.
- GUARD_TICKS, 24, cycles at the start of each slot during which all digits are dark.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- value_in  in  4*DIGITS  hex value; nibble i drives digit i; digit 0 is least significant (rightmost).
- dp_in  in  DIGITS  decimal point per digit, active high.
- load  in  1  capture value_in/dp_in into the pending register (level sampled each clk).
- blank_lz  in  1  enable leading-zero blanking (live level, not latched).
- load_ack  out  1  one-cycle pulse when a pending value is transferred to the display register.
- frame_start  out  1  one-cycle pulse when the slot wraps to digit 0.
- anode  out  DIGITS  digit enables, active low; bit i drives digit i.
- segments  out  7  {A,B,C,D,E,F,G}, active high.
- dp  out  1  decimal point of the lit digit, active high.

Behaviour:
- Reset (async, reset=0) clears:
  - tick counter and slot counter to 0;
  - pending, display and dp registers to 0; pending flag to 0;
  - outputs: anode all ones, segments 0, dp 0, load_ack 0, frame_start 0.
- Tick counter runs 0..REFRESH_TICKS-1.
  - At REFRESH_TICKS-1 it wraps to 0 and slot increments. Slot wraps DIGITS-1 -> 0.
  - frame_start pulses on the cycle the slot changes to 0.
- Load path:
  - load=1 copies value_in/dp_in into the pending register and sets the pending flag.
  - Repeated loads before transfer overwrite; last write wins, with a single ack.
  - Transfer occurs only at the slot wrap to 0: display <= pending, flag cleared, load_ack pulses in the same cycle as frame_start.
  - load=1 in the wrap cycle itself is captured into pending and transferred at the next wrap.
  - With no load, the display register holds its value indefinitely.
- Output stage, all outputs registered (one cycle after counter state):
  - tick < GUARD_TICKS: anode all ones, segments 0, dp 0.
  - Otherwise: anode[slot]=0 (others 1), segments=decode(display nibble[slot]), dp=display_dp[slot].
  - Anode and segment changes occur in the same cycle, so there is no stale-segment glitch.
- Hex decode (hex value of the 7-bit segments vector):
  - 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70
  - 8:7F 9:7B A:77 b:1F C:4E d:3D E:4F F:47
- Leading-zero blanking:
  - With blank_lz=1, digit i (i>0) is blanked when display nibbles i..DIGITS-1 are all zero.
  - A blanked digit keeps all anodes high for the whole slot; its dp is also suppressed.
  - Digit 0 is never blanked.

Optional Feature:
- SEG7_DIMMING_EN defined: adds input port brightness [3:0] and a free-running 4-bit PWM counter.
  - Outside the guard window, the selected anode is driven low only while pwm < brightness; segments/dp are forced to 0 when the anode is off.
  - brightness=0 gives dark; 15 gives 15/16 duty.
- Undefined: no brightness port, full duty outside the guard window.

Test Plan (DIGITS=4, REFRESH_TICKS=8, GUARD_TICKS=1):
- Release reset, no load -> anode sequence 1110,1101,1011,0111 repeating. Each slot: 1 cycle 1111, then 7 cycles active. Segments 7E on every active cycle; frame_start every 32 cycles.
- load=1 for one cycle with value 0x1A2F, dp 0010, mid-slot 2 -> old display persists until wrap. load_ack coincides with frame_start. Next frame shows digit0=47, digit1=6D with dp=1, digit2=77, digit3=30.
- blank_lz=1, value 0x0005 -> anode bits 3..1 stay 1 for the whole frame; digit0 shows 5B. Then value 0x0105 -> digit1 shows 7E, digit2 shows 30, digit3 dark.
- load 0x1111 then 0x2222 in the same frame -> exactly one load_ack; next frame all digits show 6D.
- Assert reset mid-slot 2 with display 0x1234 -> anode 1111, segments 0 and counters 0 immediately. After release, digits show 7E.
- SEG7_DIMMING_EN, brightness=4, REFRESH_TICKS=64 -> per slot, active anode low exactly 4 of each 16 cycles outside the guard. brightness=0 -> anode stays 1111.
